pwm_multi_gen: RTL and testbench
================================

Name: pwm_multi_gen

Overview:
Parametrised multi-channel PWM generator and successor to the single-channel pwm_gen. It owns its own prescaled timebase with up or up/down (centre-aligned) counting. Each channel has its own mode, polarity and compare pair. All configuration is double-buffered and becomes active only at a period boundary. It sits between the peripheral register file and the top-level pins.

Parameters:
CNT_W, 16, width of counter, period and compare values
NUM_CH, 4, number of PWM channels (1..16)
PRE_W, 8, prescaler width

Ports:
clk  input  1  peripheral clock
rst_n  input  1  asynchronous active-low reset
en  input  1  timebase and output enable
cfg_wr  input  1  one-cycle strobe; samples all cfg_* inputs into shadow registers
cfg_period  input  CNT_W  terminal count
cfg_prescale  input  PRE_W  counter advances every cfg_prescale+1 clk cycles
cfg_updown  input  1  0 = up-count, 1 = up/down
cfg_mode  input  2*NUM_CH  per-channel mode, channel i at [2i+1:2i]
cfg_pol  input  NUM_CH  per-channel polarity; 1 = inverted output
cfg_cmp1  input  CNT_W*NUM_CH  per-channel compare1, channel i at [CNT_W*i +: CNT_W]
cfg_cmp2  input  CNT_W*NUM_CH  per-channel compare2, same packing
count_val  output  CNT_W  current counter value (registered)
period_tick  output  1  one-cycle pulse at period boundary
update_ack  output  1  one-cycle pulse when shadow registers are copied to active
pwm_out  output  NUM_CH  registered PWM outputs

Behaviour:
- Reset, asynchronous:
  - count_val = 0, prescaler = 0, direction = up.
  - period_tick = 0, update_ack = 0, pwm_out = 0.
  - All shadow and active registers = 0; pending = 0.
- Configuration:
  - cfg_wr loads every cfg_* input into the shadow registers and sets pending.
  - The active registers drive all logic. The shadow registers never affect outputs directly.
- Advance: when en=1 and prescaler == active prescale, the counter steps and the prescaler clears. Otherwise the prescaler increments.
- Up mode: counter counts 0..period, then 0. period_tick pulses on the advance cycle where count_val == period.
- Up/down mode:
  - Counter counts 0 up to period, then down to 0, reversing direction at each end. Each end value is held for exactly one step, with no double count.
  - period_tick pulses on the advance where count_val == 0 while counting down, and on the very first advance after enable.
- period = 0: count_val stays 0 and period_tick pulses on every advance.
- Boundary update: on a period_tick cycle with pending=1:
  - Active registers <= shadow, pending cleared.
  - update_ack pulses in the following cycle.
  - The new period, prescale and mode apply from the next advance.
- Simultaneous events:
  - cfg_wr on a boundary cycle: the boundary copies the pre-write shadow contents.
  - The new write lands in shadow and pending remains 1, so it is applied at the next boundary.
- en=0:
  - Counter and prescaler are held at 0 with direction up; period_tick = 0.
  - pwm_out[i] = cfg_pol active bit (inactive level).
  - If pending, active <= shadow immediately, pending cleared, and update_ack pulses once.
- Per-channel raw level from active registers and the current count register:
  - 00 left-aligned: count < cmp1.
  - 01 right-aligned: count >= cmp1.
  - 10 window: cmp1 <= count < cmp2; constant 0 if cmp1 >= cmp2.
  - 11: 0.
- pwm_out[i] = raw ^ pol[i], registered. This gives one clk of latency after count_val. Channels are independent.
- All comparisons are unsigned CNT_W-bit. The counter never exceeds period; a period lowered by an update takes effect only at the boundary, so no overshoot is possible.
- Mid-operation reset: everything returns to reset values immediately, asynchronously. Pending writes are lost.

Test Plan:
- Reset/idle: assert rst_n=0 mid-count (count_val=5) -> all outputs 0 immediately. Then en=0 with cfg_pol=4'b1010 written -> update_ack pulse, pwm_out=4'b1010.
- Up left-aligned: period=9, prescale=0, ch0 mode 00, cmp1=3 -> pwm_out[0] high for count 0..2, one clk behind count_val. 10-cycle period; period_tick every 10 clks.
- Prescale and modes: prescale=2, period=4; ch1 mode 01 cmp1=2; ch2 mode 10 cmp1=1 cmp2=3 -> count steps every 3 clks.
  - ch1 high for counts 2..4.
  - ch2 high for counts 1..2.
  - cmp1=3, cmp2=1 -> ch2 constant 0.
- Up/down: period=4, cmp1=2 mode 00 -> sequence 0,1,2,3,4,3,2,1,0,1… Output is symmetric around count 4; period_tick at each count 0 reached while counting down.
- Double buffering: running period=9, write cmp1=7 mid-period -> old duty kept until period_tick, then update_ack and the new duty apply. A cfg_wr in the same cycle as period_tick is applied one period later.
- Edge values: period=0 -> count stays 0 and period_tick every advance. cmp1=0 mode 00 -> always low. cmp1=period+1 mode 00 -> always high. pol=1 inverts each case.

Source files
------------

// File: rtl/pwm_multi_gen.sv
// rtl/pwm_multi_gen.sv - multi-channel double-buffered PWM generator with prescaled up or up/down timebase
module pwm_multi_gen #(
  parameter int CNT_W  = 16,
  parameter int NUM_CH = 4,
  parameter int PRE_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    cfg_wr,
  input  logic [CNT_W-1:0]        cfg_period,
  input  logic [PRE_W-1:0]        cfg_prescale,
  input  logic                    cfg_updown,
  input  logic [2*NUM_CH-1:0]     cfg_mode,
  input  logic [NUM_CH-1:0]       cfg_pol,
  input  logic [CNT_W*NUM_CH-1:0] cfg_cmp1,
  input  logic [CNT_W*NUM_CH-1:0] cfg_cmp2,
  output logic [CNT_W-1:0]        count_val,
  output logic                    period_tick,
  output logic                    update_ack,
  output logic [NUM_CH-1:0]       pwm_out
);

  // shadow copy, written by cfg_wr, never seen by the datapath
  logic [CNT_W-1:0]        sh_period_q;
  logic [PRE_W-1:0]        sh_prescale_q;
  logic                    sh_updown_q;
  logic [2*NUM_CH-1:0]     sh_mode_q;
  logic [NUM_CH-1:0]       sh_pol_q;
  logic [CNT_W*NUM_CH-1:0] sh_cmp1_q;
  logic [CNT_W*NUM_CH-1:0] sh_cmp2_q;

  // active copy, the only configuration the timebase and channels use
  logic [CNT_W-1:0]        act_period_q;
  logic [PRE_W-1:0]        act_prescale_q;
  logic                    act_updown_q;
  logic [2*NUM_CH-1:0]     act_mode_q;
  logic [NUM_CH-1:0]       act_pol_q;
  logic [CNT_W*NUM_CH-1:0] act_cmp1_q;
  logic [CNT_W*NUM_CH-1:0] act_cmp2_q;

  logic                    pending_q, pending_d;
  logic                    ack_q;
  logic                    copy;

  // timebase state; dir_q = 1 while counting down
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PRE_W-1:0]        presc_q, presc_d;
  logic                    dir_q, dir_d;
  logic                    started_q, started_d;
  logic                    adv;
  logic                    tick_c;

  logic [NUM_CH-1:0]       raw;
  logic [NUM_CH-1:0]       pwm_q, pwm_d;

  // timebase next state: prescaler, counter, direction and boundary detection
  always_comb begin
    adv       = en && (presc_q == act_prescale_q);
    tick_c    = 1'b0;
    cnt_d     = cnt_q;
    presc_d   = presc_q;
    dir_d     = dir_q;
    started_d = started_q;
    if (!en) begin
      cnt_d     = '0;
      presc_d   = '0;
      dir_d     = 1'b0;
      started_d = 1'b0;
    end else if (!adv) begin
      presc_d = presc_q + 1'b1;
    end else begin
      presc_d   = '0;
      started_d = 1'b1;
      if (act_period_q == '0) begin
        cnt_d  = '0;
        dir_d  = 1'b0;
        tick_c = 1'b1;
      end else if (!act_updown_q) begin
        dir_d = 1'b0;
        if (cnt_q >= act_period_q) begin
          cnt_d  = '0;
          tick_c = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        // the first advance after enable opens a centre-aligned period
        tick_c = !started_q;
        if (!dir_q) begin
          if (cnt_q >= act_period_q) begin
            cnt_d = cnt_q - 1'b1;
            dir_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          if (cnt_q == '0) begin
            cnt_d  = cnt_q + 1'b1;
            dir_d  = 1'b0;
            tick_c = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
    end
  end

  // timebase registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      presc_q   <= '0;
      dir_q     <= 1'b0;
      started_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      presc_q   <= presc_d;
      dir_q     <= dir_d;
      started_q <= started_d;
    end
  end

  // active takes the shadow at a boundary, or at once while idle; a write in the
  // same cycle lands in shadow and stays pending for the following boundary
  assign copy      = pending_q && (tick_c || !en);
  assign pending_d = cfg_wr || (pending_q && !copy);

  // shadow capture, shadow-to-active transfer, pending flag and acknowledge pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_period_q    <= '0;
      sh_prescale_q  <= '0;
      sh_updown_q    <= 1'b0;
      sh_mode_q      <= '0;
      sh_pol_q       <= '0;
      sh_cmp1_q      <= '0;
      sh_cmp2_q      <= '0;
      act_period_q   <= '0;
      act_prescale_q <= '0;
      act_updown_q   <= 1'b0;
      act_mode_q     <= '0;
      act_pol_q      <= '0;
      act_cmp1_q     <= '0;
      act_cmp2_q     <= '0;
      pending_q      <= 1'b0;
      ack_q          <= 1'b0;
    end else begin
      if (cfg_wr) begin
        sh_period_q   <= cfg_period;
        sh_prescale_q <= cfg_prescale;
        sh_updown_q   <= cfg_updown;
        sh_mode_q     <= cfg_mode;
        sh_pol_q      <= cfg_pol;
        sh_cmp1_q     <= cfg_cmp1;
        sh_cmp2_q     <= cfg_cmp2;
      end
      if (copy) begin
        act_period_q   <= sh_period_q;
        act_prescale_q <= sh_prescale_q;
        act_updown_q   <= sh_updown_q;
        act_mode_q     <= sh_mode_q;
        act_pol_q      <= sh_pol_q;
        act_cmp1_q     <= sh_cmp1_q;
        act_cmp2_q     <= sh_cmp2_q;
      end
      pending_q <= pending_d;
      ack_q     <= copy;
    end
  end

  // per-channel raw level from the current count; window is empty when cmp1 >= cmp2
  always_comb begin
    raw = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (act_mode_q[2*i +: 2])
        2'b00:   raw[i] = cnt_q < act_cmp1_q[CNT_W*i +: CNT_W];
        2'b01:   raw[i] = cnt_q >= act_cmp1_q[CNT_W*i +: CNT_W];
        2'b10:   raw[i] = (cnt_q >= act_cmp1_q[CNT_W*i +: CNT_W]) &&
                          (cnt_q <  act_cmp2_q[CNT_W*i +: CNT_W]);
        default: raw[i] = 1'b0;
      endcase
    end
    pwm_d = en ? (raw ^ act_pol_q) : act_pol_q;
  end

  // registered pin drivers, one clock behind count_val
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  assign count_val   = cnt_q;
  assign update_ack  = ack_q;
  assign pwm_out     = pwm_q;
  // boundary pulse is combinational with the advance, held low while in reset
  assign period_tick = rst_n & tick_c;

endmodule

// File: tb/tb_pwm_multi_gen.sv
// tb/tb_pwm_multi_gen.sv - scoreboard bench for pwm_multi_gen
module tb_pwm_multi_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        cfg_wr;
  logic [15:0] cfg_period;
  logic [7:0]  cfg_prescale;
  logic        cfg_updown;
  logic [7:0]  cfg_mode;
  logic [3:0]  cfg_pol;
  logic [63:0] cfg_cmp1;
  logic [63:0] cfg_cmp2;
  logic [15:0] count_val;
  logic        period_tick;
  logic        update_ack;
  logic [3:0]  pwm_out;

  pwm_multi_gen #(.CNT_W(16), .NUM_CH(4), .PRE_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .cfg_wr       (cfg_wr),
    .cfg_period   (cfg_period),
    .cfg_prescale (cfg_prescale),
    .cfg_updown   (cfg_updown),
    .cfg_mode     (cfg_mode),
    .cfg_pol      (cfg_pol),
    .cfg_cmp1     (cfg_cmp1),
    .cfg_cmp2     (cfg_cmp2),
    .count_val    (count_val),
    .period_tick  (period_tick),
    .update_ack   (update_ack),
    .pwm_out      (pwm_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          idx;
    logic [15:0] cnt;
    logic        tick;
    logic        ack;
    logic [3:0]  pwm;
    bit          chk_cnt;
    bit          chk_pwm;
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;

  // monitor: one expected item per falling edge while the scoreboard holds any
  initial begin
    exp_t e;
    bit   ok;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        ok = (period_tick === e.tick) && (update_ack === e.ack);
        if (e.chk_cnt && (count_val !== e.cnt)) ok = 1'b0;
        if (e.chk_pwm && (pwm_out !== e.pwm)) ok = 1'b0;
        total = total + 1;
        if (ok) passed = passed + 1;
        else $display("FAIL %s[%0d]: got cnt=%0d tick=%0b ack=%0b pwm=%b, expected cnt=%0d tick=%0b ack=%0b pwm=%b",
                      e.name, e.idx, count_val, period_tick, update_ack, pwm_out,
                      e.cnt, e.tick, e.ack, e.pwm);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string n, input int k, input logic [15:0] c, input logic t,
                      input logic a, input logic [3:0] p, input bit cc, input bit cp);
    exp_t e;
    e.name = n; e.idx = k; e.cnt = c; e.tick = t; e.ack = a; e.pwm = p;
    e.chk_cnt = cc; e.chk_pwm = cp;
    exp_q.push_back(e);
  endtask

  function automatic logic [63:0] pk(input logic [15:0] a0, input logic [15:0] a1,
                                     input logic [15:0] a2, input logic [15:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic wait_drain();
    for (int i = 0; i < 2000; i++) begin
      if (exp_q.size() == 0) return;
      step();
    end
    $display("FAIL drain: %0d items left, expected 0", exp_q.size());
    $fatal(1, "scoreboard did not drain");
  endtask

  // stop the timebase, write a full config, let the idle copy take it (ack expected)
  task automatic restart(input logic [15:0] per, input logic [7:0] pre, input logic ud,
                         input logic [7:0] mode, input logic [3:0] pol,
                         input logic [63:0] c1, input logic [63:0] c2);
    step();
    en = 1'b0;
    cfg_period = per; cfg_prescale = pre; cfg_updown = ud;
    cfg_mode = mode; cfg_pol = pol; cfg_cmp1 = c1; cfg_cmp2 = c2;
    cfg_wr = 1'b1;
    step();
    cfg_wr = 1'b0;
    step();
    push("idle_ack", 0, 16'd0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
    step();
  endtask

  function automatic int ud_cnt(input int k);
    int m;
    m = k % 8;
    return (m <= 4) ? m : 8 - m;
  endfunction

  initial begin
    bit         found;
    logic [3:0] p;
    int         c;
    int         cp;
    rst_n = 1'b0; en = 1'b0; cfg_wr = 1'b0;
    cfg_period = '0; cfg_prescale = '0; cfg_updown = 1'b0;
    cfg_mode = '0; cfg_pol = '0; cfg_cmp1 = '0; cfg_cmp2 = '0;
    repeat (3) step();
    rst_n = 1'b1;

    // up, left-aligned ch0 cmp1=3; ch3 right-aligned cmp1=0 is always high
    restart(16'd9, 8'd0, 1'b0, 8'h40, 4'b0000, pk(16'd3, 16'd0, 16'd0, 16'd0), '0);
    en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      p = (k == 0) ? 4'b0000 : {1'b1, 2'b00, (((k - 1) % 10) < 3)};
      push("up_left", k, 16'(k % 10), (k % 10) == 9, 1'b0, p, 1'b1, 1'b1);
    end
    wait_drain();

    // asynchronous reset mid-count
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (count_val == 16'd5) found = 1'b1;
      else step();
    end
    if (!found) begin
      $display("FAIL reset_setup: count_val=%0d never reached 5", count_val);
      $fatal(1, "setup lost");
    end
    rst_n = 1'b0;
    push("async_reset", 0, 16'd0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
    step();
    step();
    rst_n = 1'b1;

    // idle write of polarity: all channels mode 11 show pol
    restart(16'd9, 8'd0, 1'b0, 8'hFF, 4'b1010, '0, '0);
    en = 1'b1;
    for (int k = 0; k < 12; k++)
      push("idle_pol", k, 16'(k % 10), (k % 10) == 9, 1'b0, 4'b1010, 1'b1, 1'b1);
    wait_drain();

    // prescale 2, period 4: ch1 right-aligned cmp1=2, ch2 window [1,3), ch0 cmp1=0 low
    restart(16'd4, 8'd2, 1'b0, 8'h24, 4'b0000,
            pk(16'd0, 16'd2, 16'd1, 16'd0), pk(16'd0, 16'd0, 16'd3, 16'd0));
    en = 1'b1;
    for (int k = 0; k < 45; k++) begin
      c  = (k / 3) % 5;
      cp = ((k - 1) / 3) % 5;
      p  = (k == 0) ? 4'b0000 : {1'b0, (cp >= 1 && cp < 3), (cp >= 2), 1'b0};
      push("presc_modes", k, 16'(c), ((k + 1) % 3 == 0) && (c == 4), 1'b0, p, 1'b1, 1'b1);
    end
    wait_drain();

    // inverted window cmp1=3 cmp2=1 is constant low
    restart(16'd4, 8'd2, 1'b0, 8'h24, 4'b0000,
            pk(16'd0, 16'd2, 16'd3, 16'd0), pk(16'd0, 16'd0, 16'd1, 16'd0));
    en = 1'b1;
    for (int k = 0; k < 15; k++) begin
      c  = (k / 3) % 5;
      cp = ((k - 1) / 3) % 5;
      p  = (k == 0) ? 4'b0000 : {2'b00, (cp >= 2), 1'b0};
      push("empty_window", k, 16'(c), ((k + 1) % 3 == 0) && (c == 4), 1'b0, p, 1'b1, 1'b1);
    end
    wait_drain();

    // up/down period 4: ch0 left cmp1=2, ch1 right cmp1=4
    restart(16'd4, 8'd0, 1'b1, 8'hF4, 4'b0000, pk(16'd2, 16'd4, 16'd0, 16'd0), '0);
    en = 1'b1;
    for (int k = 0; k < 24; k++) begin
      p = (k == 0) ? 4'b0000 : {2'b00, (ud_cnt(k - 1) >= 4), (ud_cnt(k - 1) < 2)};
      push("updown", k, 16'(ud_cnt(k)), (k % 8) == 0, 1'b0, p, 1'b1, 1'b1);
    end
    wait_drain();

    // double buffering: mid-period write, then a pending write overlapped by a boundary write
    restart(16'd9, 8'd0, 1'b0, 8'hFC, 4'b0000, pk(16'd3, 16'd0, 16'd0, 16'd0), '0);
    en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      cp = (k - 1 < 10) ? 3 : (k - 1 < 20) ? 7 : (k - 1 < 30) ? 6 : 5;
      p  = (k == 0) ? 4'b0000 : {3'b000, (((k - 1) % 10) < cp)};
      push("dbl_buf", k, 16'(k % 10), (k % 10) == 9, (k == 10 || k == 20 || k == 30), p, 1'b1, 1'b1);
    end
    repeat (4) step();
    cfg_cmp1 = pk(16'd7, 16'd0, 16'd0, 16'd0);
    cfg_wr = 1'b1;
    step();
    cfg_wr = 1'b0;
    repeat (9) step();
    cfg_cmp1 = pk(16'd6, 16'd0, 16'd0, 16'd0);
    cfg_wr = 1'b1;
    step();
    cfg_wr = 1'b0;
    repeat (4) step();
    cfg_cmp1 = pk(16'd5, 16'd0, 16'd0, 16'd0);
    cfg_wr = 1'b1;
    step();
    cfg_wr = 1'b0;
    wait_drain();

    // period 0: tick every advance; cmp1=0 low, cmp1=1 high, pol inverts both
    restart(16'd0, 8'd0, 1'b0, 8'h00, 4'b1100, pk(16'd0, 16'd1, 16'd0, 16'd1), '0);
    en = 1'b1;
    for (int k = 0; k < 10; k++)
      push("period0", k, 16'd0, 1'b1, 1'b0, (k == 0) ? 4'b1100 : 4'b0110, 1'b1, 1'b1);
    wait_drain();

    // period 0, prescale 1, up/down: tick on every second clock
    restart(16'd0, 8'd1, 1'b1, 8'hFF, 4'b0000, '0, '0);
    en = 1'b1;
    for (int k = 0; k < 8; k++)
      push("period0_presc", k, 16'd0, (k % 2) == 1, 1'b0, 4'b0000, 1'b1, 1'b1);
    wait_drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
